// File: rtl/sevenseg_scan_mux_if.sv
// Display-side bundle for sevenseg_scan_mux: value/mask inputs and the anode/segment drives.
// The driving block uses master; the display driver itself uses slave.
interface sevenseg_scan_mux_if #(
  parameter int unsigned DIGITS = 8
);
  logic                  i_en;
  logic                  i_load;
  logic [4*DIGITS-1:0]   i_value;
  logic [DIGITS-1:0]     i_dp;
  logic [DIGITS-1:0]     i_blank;
  logic [DIGITS-1:0]     o_an;
  logic [6:0]            o_seg;
  logic                  o_dp;

  modport master (
    output i_en, i_load, i_value, i_dp, i_blank,
    input  o_an, o_seg, o_dp
  );

  modport slave (
    input  i_en, i_load, i_value, i_dp, i_blank,
    output o_an, o_seg, o_dp
  );
endinterface

// File: rtl/sevenseg_scan_mux.sv
// Time-multiplexed seven-segment hex driver with prescaled scan, dead time, snapshot and masks.
// Define SEVENSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scan_mux #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned DEAD_CYCLES    = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input logic                 i_clk,
  input logic                 i_rst,
  sevenseg_scan_mux_if.slave  disp_io
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] DeadCnt = CntW'(DEAD_CYCLES);
  localparam logic [IdxW-1:0] IdxMax  = IdxW'(DIGITS - 1);
  localparam logic [6:0]      SegOff  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic            DpOff   = SEG_ACTIVE_LOW;

  typedef enum logic {StDead, StOn} phase_e;

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [IdxW-1:0]     slot_q;
  phase_e              phase_q, phase_d;
  logic [4*DIGITS-1:0] snap_value_q;
  logic [DIGITS-1:0]   snap_dp_q, snap_blank_q;
  logic [DIGITS-1:0]   dark_mask;
  logic [DIGITS-1:0]   an_d;
  logic [6:0]          seg_d;
  logic                dp_d;
  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [3:0]          nib;
  logic                lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    unique case (n)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      4'hF: s = 7'h38;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // Phase tracks the cnt value one cycle behind, paired with slot_q as the registered idx.
  always_comb begin
    phase_d = phase_q;
    if (DEAD_CYCLES == 0) begin
      phase_d = StOn;
    end else begin
      unique case (phase_q)
        StDead:  if (cnt_q == DeadCnt) phase_d = StOn;
        StOn:    if (cnt_q == '0)      phase_d = StDead;
        default: phase_d = StDead;
      endcase
    end
  end

`ifdef SEVENSEG_LZB_EN
  // Walk down from the top digit; a non-zero nibble or a lit dp ends the leading-zero run.
  always_comb begin
    logic lead;
    lead      = 1'b1;
    dark_mask = snap_blank_q;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lead = lead && (snap_value_q[4*k +: 4] == 4'h0) && !snap_dp_q[k];
      if (lead) dark_mask[k] = 1'b1;
    end
  end
`else
  assign dark_mask = snap_blank_q;
`endif

  always_comb begin
    nib   = snap_value_q[{slot_q, 2'b00} +: 4];
    lit   = (phase_q == StOn) && disp_io.i_en && !dark_mask[slot_q];
    an_d  = '1;
    seg_d = SegOff;
    dp_d  = DpOff;
    if (lit) begin
      an_d[slot_q] = 1'b0;
      seg_d        = SEG_ACTIVE_LOW ? seg_decode(nib) : ~seg_decode(nib);
      dp_d         = snap_dp_q[slot_q] ^ SEG_ACTIVE_LOW;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      slot_q       <= '0;
      phase_q      <= StDead;
      snap_value_q <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      an_q         <= '1;
      seg_q        <= SegOff;
      dp_q         <= DpOff;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      slot_q  <= idx_q;
      phase_q <= phase_d;
      if (disp_io.i_load) begin
        snap_value_q <= disp_io.i_value;
        snap_dp_q    <= disp_io.i_dp;
        snap_blank_q <= disp_io.i_blank;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign disp_io.o_an  = an_q;
  assign disp_io.o_seg = seg_q;
  assign disp_io.o_dp  = dp_q;

endmodule

// File: doc/sevenseg_scan_mux.md
Name: sevenseg_scan_mux

Overview:
- Parametrised, time-multiplexed hex display driver for common-anode seven-segment banks on the Nexys A7, in the clk_core domain of the SweRVolf toplevel.
- Replaces the fixed 8-digit, one-digit-per-clock anode rotator with:
  - a programmable refresh prescaler;
  - inter-digit dead time, for anti-ghosting;
  - a tear-free snapshot register, loaded by i_load;
  - per-digit decimal-point and blank masks;
  - selectable segment polarity.
- Typical sources: branch counters or GPIO words from swervolf_core.

Parameters:
- DIGITS, 8, number of digits/anodes (1..16).
- REFRESH_DIV, 100000, clk cycles per digit slot (>= DEAD_CYCLES+1).
- DEAD_CYCLES, 16, cycles at slot start with all anodes off (0 = no dead time).
- SEG_ACTIVE_LOW, 1, 1: o_seg/o_dp driven low = lit. 0: high = lit. Anodes are always active-low.

Ports:
- i_clk  in  1  clock. Only clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_en  in  1  display enable. 0 blanks all anodes; scan counters keep running.
- i_load  in  1  capture i_value/i_dp/i_blank into snapshot.
- i_value  in  4*DIGITS  hex nibbles; nibble k drives digit k.
- i_dp  in  DIGITS  decimal point per digit, 1 = lit.
- i_blank  in  DIGITS  force digit dark, 1 = blank.
- o_an  out  DIGITS  anode enables, active-low, at most one bit low.
- o_seg  out  7  segments {a,b,c,d,e,f,g} = o_seg[6:0].
- o_dp  out  1  decimal point.

Behaviour:
- Reset, i_rst high at posedge:
  - cnt=0, idx=0, snapshot value/dp/blank=0.
  - o_an all ones.
  - o_seg and o_dp in the unlit state: 7'h7F/1 if SEG_ACTIVE_LOW, else 0/0.
  - Reset mid-scan aborts the current slot immediately; no partial-slot carryover.
- Prescaler:
  - cnt is $clog2(REFRESH_DIV) bits wide and counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1: cnt<=0 and idx<=(idx==DIGITS-1)?0:idx+1.
- Slot phase, two states evaluated each cycle:
  - DEAD while cnt<DEAD_CYCLES.
  - ON while cnt>=DEAD_CYCLES.
  - DEAD->ON when cnt reaches DEAD_CYCLES.
  - ON->DEAD on cnt wrap.
  - DEAD_CYCLES=0 means the slot is always ON.
- Outputs are registered from (phase, idx, snapshot), with one-cycle latency:
  - o_an bit idx is low iff phase==ON, i_en==1 and snap_blank[idx]==0.
  - Otherwise o_an is all ones and o_seg/o_dp are unlit.
  - Segment decode of snap_value[4*idx+:4], active-low codes, inverted when SEG_ACTIVE_LOW=0:
    - 0:01, 1:4F, 2:12, 3:06, 4:4C, 5:24, 6:20, 7:0F
    - 8:00, 9:04, A:08, B:60, C:31, D:42, E:30, F:38
  - o_dp = snap_dp[idx], with polarity applied.
- Snapshot:
  - i_load at posedge updates all three snapshot fields together.
  - The new value is visible on the output register one cycle later if the slot is ON.
  - i_load held high tracks the inputs every cycle.
  - i_load concurrent with i_rst: reset wins.
- i_en deassert blanks the next output register update. Reassert resumes at the current idx/cnt with no restart.
- Invariant: o_an never has more than one bit low, in any cycle including reset exit.

Optional Feature:
- Macro SEVENSEG_LZB_EN enables leading-zero blanking.
- Defined:
  - Digit k (k>=1) is treated as blanked when its snapshot nibble and all higher nibbles are zero.
  - Blanked digits get anode high during their slot.
  - Digit 0 is never LZB-blanked, so value 0 shows "0".
  - A set snap_dp bit on a digit suppresses LZB for that digit and all lower digits.
- Undefined: all non-masked digits are displayed, leading zeros included.

Test Plan (DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, SEG_ACTIVE_LOW=1 unless stated):
- Reset and scan sequencing:
  - Stimulus: hold i_rst 3 cycles, release, i_en=1.
  - Required: o_an=4'hF, o_seg=7'h7F, o_dp=1 during reset.
  - Required: o_an=4'hF for the first 3 cycles after release, then 4'hE for 6 cycles.
  - Required: then F,F, then 4'hD. After 32 cycles the sequence returns to 4'hE.
- Decode and snapshot:
  - Stimulus: i_value=16'h3A0F, i_load pulse.
  - Required: digit0 o_seg=7'h38, digit1=7'h01, digit2=7'h08, digit3=7'h06.
  - Stimulus: change i_value without i_load.
  - Required: no output change.
- Masks:
  - Stimulus: i_dp=4'b0100, i_blank=4'b0010, load.
  - Required: o_dp=0 only in the digit2 slot. o_an stays 4'hF in the digit1 slot.
- Enable and mid-scan reset:
  - Stimulus: i_en=0 for 20 cycles.
  - Required: o_an=4'hF throughout; idx advances, so display resumes at the correct digit.
  - Stimulus: i_rst asserted at cnt=5 of slot 2.
  - Required: next cycle returns to the reset values.
- Polarity (SEG_ACTIVE_LOW=0):
  - Stimulus: value 8 on digit0.
  - Required: o_seg=7'h7F and o_dp=0 when dp is not set.
- SEVENSEG_LZB_EN:
  - Stimulus: i_value=16'h0050, load.
  - Required: digits 3 and 2 dark; digit1 shows 7'h24; digit0 shows 7'h01.
  - Stimulus: i_value=0.
  - Required: only digit0 lit, showing 7'h01.
